// File: rtl/pmem_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pmem_rr_arbiter_pkg
// Purpose  : Shared types, default sizes and helpers for the pmem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package pmem_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int C_NUM_REQ   = 4;
    localparam int C_ADDR_W    = 4;
    localparam int C_DATA_W    = 32;
    localparam int C_MAX_BURST = 8;

    // Requester id width; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pmem_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pmem_rr_arbiter_if
// Purpose  : Requester-side and SRAM-side signal bundle of the pmem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface pmem_rr_arbiter_if
    import pmem_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = C_NUM_REQ,
    parameter int ADDR_W  = C_ADDR_W,
    parameter int DATA_W  = C_DATA_W
) ();

    localparam int C_OWN_W = owner_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic                      mem_wr;
    logic                      mem_rd;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic [C_OWN_W-1:0]        owner;
    logic                      locked;
    logic                      burst_err;

    modport slave (
        input  req, req_wr, req_last, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_wr, mem_rd, mem_addr, mem_wdata,
               owner, locked, burst_err
    );

    modport master (
        output req, req_wr, req_last, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_wr, mem_rd, mem_addr, mem_wdata,
               owner, locked, burst_err
    );

endinterface
`default_nettype wire

// File: rtl/pmem_rr_arbiter_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr_pick
// Purpose  : Rotating-priority picker: first set request at or above ptr.
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  wire logic [N-1:0] req_i,
    input  wire logic [W-1:0] ptr_i,
    output logic      [N-1:0] gnt_o,
    output logic      [W-1:0] idx_o,
    output logic              any_o
);

    int           w_j;
    logic [W-1:0] w_cand;

    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        w_j    = 0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_j    = (int'(ptr_i) + k) % N;
            w_cand = W'(w_j);
            if (!any_o && req_i[w_cand]) begin
                any_o         = 1'b1;
                idx_o         = w_cand;
                gnt_o[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pmem_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_rr_arbiter
// Purpose  : Round-robin, burst-locking arbiter in front of one registered SRAM.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_rr_arbiter
    import pmem_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = C_NUM_REQ,
    parameter int ADDR_W    = C_ADDR_W,
    parameter int DATA_W    = C_DATA_W,
    parameter int MAX_BURST = C_MAX_BURST
) (
    input  wire logic       clk,
    input  wire logic       reset,
    pmem_rr_arbiter_if.slave bus
);

    localparam int                OWN_W = owner_w(NUM_REQ);
    localparam int                CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  C_MAX = CNT_W'(MAX_BURST);

    arb_state_e           state_q;
    logic [OWN_W-1:0]     ptr_q;
    logic [OWN_W-1:0]     owner_q;
    logic [OWN_W-1:0]     rd_id_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic                 burst_err_q;
    logic                 mem_wr_q;
    logic                 mem_rd_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [NUM_REQ-1:0]   rvalid_q;

    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic [OWN_W-1:0]     w_pick_idx;
    logic                 w_pick_any;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [OWN_W-1:0]     w_sel;
    logic                 w_acc;
    logic                 w_sel_wr;
    logic                 w_sel_last;
    logic [OWN_W-1:0]     w_next_id;
    logic [CNT_W-1:0]     w_cnt_inc;

    arb_rr_pick #(
        .N (NUM_REQ),
        .W (OWN_W)
    ) u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (w_pick_gnt),
        .idx_o (w_pick_idx),
        .any_o (w_pick_any)
    );

    // While locked only the owner is eligible; grants are suppressed in reset.
    always_comb begin
        w_sel = owner_q;
        w_gnt = '0;
        if (reset) begin
            w_gnt = '0;
        end else if (state_q == ST_IDLE) begin
            w_sel = w_pick_idx;
            if (w_pick_any) begin
                w_gnt = w_pick_gnt;
            end
        end else if (bus.req[owner_q]) begin
            w_gnt = NUM_REQ'(1) << owner_q;
        end
    end

    assign w_acc      = |w_gnt;
    assign w_sel_wr   = bus.req_wr[w_sel];
    assign w_sel_last = bus.req_last[w_sel];
    assign w_next_id  = (w_sel == OWN_W'(NUM_REQ - 1)) ? '0 : w_sel + OWN_W'(1);
    assign w_cnt_inc  = beat_cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            rd_id_q     <= '0;
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rvalid_q    <= '0;
        end else begin
            mem_wr_q <= w_acc &  w_sel_wr;
            mem_rd_q <= w_acc & ~w_sel_wr;
            // Read tag travels one stage behind mem_rd, matching the SRAM latency.
            rvalid_q <= mem_rd_q ? (NUM_REQ'(1) << rd_id_q) : '0;
            if (w_acc) begin
                mem_addr_q  <= bus.req_addr[w_sel*ADDR_W +: ADDR_W];
                mem_wdata_q <= bus.req_wdata[w_sel*DATA_W +: DATA_W];
                rd_id_q     <= w_sel;
                owner_q     <= w_sel;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_acc) begin
                        if (w_sel_last) begin
                            ptr_q <= w_next_id;
                        end else begin
                            state_q    <= ST_LOCKED;
                            beat_cnt_q <= CNT_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_acc) begin
                        beat_cnt_q <= w_cnt_inc;
                        if (w_sel_last || (w_cnt_inc == C_MAX)) begin
                            state_q    <= ST_IDLE;
                            ptr_q      <= w_next_id;
                            beat_cnt_q <= '0;
                            if (!w_sel_last) begin
                                burst_err_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.rvalid    = rvalid_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.burst_err = burst_err_q;

endmodule
`default_nettype wire

// File: doc/pmem_rr_arbiter.md
# pmem_rr_arbiter

Round-robin arbiter that shares one single-port, registered-output SRAM (e.g. pmem) among NUM_REQ requesters such as the core controller's SFU writeback path, the host readout path and the debug/preload path. It accepts one access per cycle, locks the winner for the length of a burst, registers the selected access onto the SRAM pins and routes the read-valid strobe back to the issuing requester with fixed latency.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- ADDR_W, 4: SRAM address width
- DATA_W, 32: SRAM data width
- MAX_BURST, 8: maximum beats per lock before forced release

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req  in  NUM_REQ  per-requester access request
- req_wr  in  NUM_REQ  1 = write, 0 = read
- req_last  in  NUM_REQ  current beat ends the burst
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot, combinational; beat accepted this cycle
- rvalid  out  NUM_REQ  one-hot; rdata valid for that requester
- rdata  out  DATA_W  mem_rdata passthrough
- mem_wr, mem_rd  out  1  SRAM write/read enables, active-high
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_rd
- owner  out  clog2(NUM_REQ)  current/last granted requester
- locked  out  1  burst lock active
- burst_err  out  1  sticky; a burst hit MAX_BURST without req_last

## Operation
- States: IDLE, LOCKED.
- IDLE: if any req, winner = first asserted req scanning from ptr upward, wrapping mod NUM_REQ; gnt[winner]=1; owner<=winner. If req_last[winner]=1 stay IDLE, ptr<=winner+1 mod NUM_REQ; else go LOCKED, beat_cnt<=1.
- LOCKED: only owner is considered. req[owner]=1 -> gnt[owner]=1, beat_cnt+1. Accepted beat with req_last=1, or beat_cnt reaching MAX_BURST -> IDLE, ptr<=owner+1. Forced release without req_last also sets burst_err. req[owner]=0 -> bubble, no gnt, lock held.
- Other requesters' req ignored while LOCKED; requesters must hold req and payload stable until gnt.
- Accepted beat: next cycle mem_wr=req_wr, mem_rd=!req_wr, mem_addr/mem_wdata from owner. Without an accepted beat, mem_wr=mem_rd=0; mem_addr/mem_wdata hold.
- Read routing: issuing requester id pipelined alongside mem_rd; rvalid[id] one cycle after mem_rd.
- beat_cnt width clog2(MAX_BURST+1); addresses never modified by the arbiter.
- burst_err cleared only by reset.

## Timing
- Reset (async): state IDLE, ptr=0, owner=0, locked=0, burst_err=0, beat_cnt=0, mem_wr=mem_rd=0, mem_addr=0, mem_wdata=0, rvalid=0; gnt=0 while reset is high.
- Latency: gnt in cycle t -> mem_* in t+1 -> rvalid/rdata in t+2. Throughput one beat per cycle, including back-to-back bursts from different owners (no turnaround bubble).
- Reset mid-burst: lock and in-flight read tags dropped; no rvalid after reset deasserts.
- req and req_last together in IDLE: single-beat transfer, no lock.
- locked=1 exactly while state is LOCKED.

## Structure
- Shared package: state enum {IDLE, LOCKED}, default NUM_REQ/ADDR_W/DATA_W/MAX_BURST constants, function for owner id width.
- Sub-module arb_rr_pick: combinational rotating-priority one-hot picker (req vector, ptr -> one-hot winner, winner index).

## Test plan
- Reset then req=4'b0101, all req_last=1, reads -> gnt 0001 then 0100 alternating; rvalid[0] 2 cycles after first gnt; ptr wraps correctly.
- Requester 1 writes 4-beat burst addr 0..3 (req_last on 4th) while req[2]=1 -> gnt[1] four consecutive cycles, then gnt[2]; mem_wr high for 4 cycles with addresses 0,1,2,3.
- Owner drops req for 2 cycles mid-burst -> 2 bubble cycles, mem_wr=mem_rd=0, locked stays 1, no grant to others.
- Burst of 10 beats without req_last, MAX_BURST=8 -> forced release after 8th gnt, burst_err=1 sticky, next requester granted.
- Write 0xDEADBEEF at addr 5 from req 0, read addr 5 from req 3 -> rvalid[3] with rdata=0xDEADBEEF, rvalid[0..2]=0.
- Assert reset during LOCKED with a read in flight -> all outputs to reset values immediately, no rvalid after release, first grant goes to requester 0.
